// File: rtl/regb_fifo_uart_tx_pkg.sv
// Shared constants for the regb_fifo UART drain stage: FSM encoding and parity modes.
package regb_fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/regb_fifo_uart_tx_if.sv
// Show-ahead FIFO read port; master is the FIFO, slave is the UART drain stage.
interface regb_fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             fifo_shift_out;

  modport master (output fifo_rdata, output fifo_empty, input fifo_shift_out);
  modport slave  (input fifo_rdata, input fifo_empty, output fifo_shift_out);
endinterface

// File: rtl/regb_fifo_uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while a frame runs, flags the
// last and second-to-last cycle of every bit, and restarts on each frame start.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic i_run,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_pre_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (res || i_restart || !i_run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_run && (r_cnt == LAST);
  assign o_pre_end = i_run && (r_cnt == PRE);

endmodule

// File: rtl/regb_fifo_uart_tx.sv
// Drains a show-ahead register FIFO onto an async serial line:
// start bit, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
module regb_fifo_uart_tx
  import regb_fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic                clk,
  input  logic                res,
  regb_fifo_uart_tx_if.slave  fifo,
  input  logic                enable,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("regb_fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
    $error("regb_fifo_uart_tx: STOP_BITS must be 1 or 2");
  end
  if ((PARITY < PARITY_NONE) || (PARITY > PARITY_ODD)) begin : g_chk_par
    $error("regb_fifo_uart_tx: PARITY must be 0, 1 or 2");
  end

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_stop_cnt;
  logic             r_par;
  logic             r_tx;
  logic             r_busy;
  logic             r_frame_done;

  logic w_bit_end;
  logic w_pre_end;
  logic w_last_stop;
  logic w_pop;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .res       (res),
    .i_run     (r_state != ST_IDLE),
    .i_restart (w_pop),
    .o_bit_end (w_bit_end),
    .o_pre_end (w_pre_end)
  );

  assign w_last_stop = (r_state == ST_STOP) && (r_stop_cnt == LAST_STOP);

  // Pop from idle, or in the final stop cycle so the next frame follows with no gap.
  // Gated by res so a word is never taken from the FIFO and then dropped by reset.
  assign w_pop = !res && enable && !fifo.fifo_empty &&
                 ((r_state == ST_IDLE) || (w_last_stop && w_bit_end));

  assign fifo.fifo_shift_out = w_pop;

  always_ff @(posedge clk) begin
    // NOTE: the shift register is reset with the rest so a reset mid-frame leaves no stale word behind.
    if (res) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_par        <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_stop && w_pre_end;
      if (w_pop) begin
        r_state    <= ST_START;
        r_shift    <= fifo.fifo_rdata;
        r_par      <= (PARITY == PARITY_ODD) ? ~^fifo.fifo_rdata : ^fifo.fifo_rdata;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
      end else if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          ST_DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
              if (PARITY != PARITY_NONE) begin
                r_state <= ST_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
          ST_PAR: begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
          ST_STOP: begin
            if (r_stop_cnt == LAST_STOP) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_regb_fifo_uart_tx.sv
// Directed bench for regb_fifo_uart_tx: four instances (no parity, even, odd, two stop bits),
// each fed by a small behavioural show-ahead FIFO.
module tb_regb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1;
  logic [3:0] en  = 4'h0;

  wire [3:0] tx_w, busy_w, fd_w, shift_w, empty_w;

  logic [7:0] mem [4][16];
  logic [3:0] wr  [4] = '{default: '0};
  logic [3:0] rd  [4] = '{default: '0};
  int         pops[4] = '{default: 0};
  int         viol = 0;
  int         cyc  = 0;
  int         total = 0;
  int         bad   = 0;

  regb_fifo_uart_tx_if #(.WIDTH(8)) if0 (), if1 (), if2 (), if3 ();

  assign if0.fifo_rdata = mem[0][rd[0]];
  assign if1.fifo_rdata = mem[1][rd[1]];
  assign if2.fifo_rdata = mem[2][rd[2]];
  assign if3.fifo_rdata = mem[3][rd[3]];
  assign if0.fifo_empty = (wr[0] == rd[0]);
  assign if1.fifo_empty = (wr[1] == rd[1]);
  assign if2.fifo_empty = (wr[2] == rd[2]);
  assign if3.fifo_empty = (wr[3] == rd[3]);
  assign shift_w = {if3.fifo_shift_out, if2.fifo_shift_out, if1.fifo_shift_out, if0.fifo_shift_out};
  assign empty_w = {if3.fifo_empty, if2.fifo_empty, if1.fifo_empty, if0.fifo_empty};

  regb_fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) dut0 (
    .clk(clk), .res(res), .fifo(if0), .enable(en[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  regb_fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(1)) dut1 (
    .clk(clk), .res(res), .fifo(if1), .enable(en[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  regb_fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(2)) dut2 (
    .clk(clk), .res(res), .fifo(if2), .enable(en[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
  regb_fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY(0)) dut3 (
    .clk(clk), .res(res), .fifo(if3), .enable(en[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

  // FIFO read side: a pop strobe advances the head; strobes while empty are tallied.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (shift_w[k] === 1'b1) begin
        rd[k]   <= rd[k] + 1'b1;
        pops[k] <= pops[k] + 1;
        if (empty_w[k] === 1'b1) viol <= viol + 1;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] d);
    mem[k][wr[k]] = d;
    wr[k] = wr[k] + 1'b1;
  endtask

  // Waits for a pop, then samples one whole frame. exp_bits[j] is the j-th bit on the line.
  task automatic run_frame(input int k, input string name, input logic [11:0] exp_bits,
                           input int nbits, input int drop_at, output int pop_cyc);
    logic [11:0] obs = '0;
    bit glitch = 1'b0;
    int fd_at = -1;
    int fd_cnt = 0;
    int busy_cnt = 0;
    int waited = 0;
    #1;
    while (shift_w[k] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (shift_w[k] !== 1'b1) begin
      bad++;
      $display("FAIL %s_pop: no pop strobe within %0d cycles", name, waited);
      pop_cyc = -1;
      return;
    end
    pop_cyc = cyc;
    for (int t = 1; t <= nbits * CPB; t++) begin
      @(negedge clk);
      if ((t - 1) % CPB == 0) obs[(t - 1) / CPB] = tx_w[k];
      else if (tx_w[k] !== obs[(t - 1) / CPB]) glitch = 1'b1;
      if (busy_w[k] === 1'b1) busy_cnt++;
      if (fd_w[k] === 1'b1) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = t;
      end
      if (t == drop_at) en[k] = 1'b0;
    end
    total++;
    if (obs !== exp_bits || glitch) begin
      bad++;
      $display("FAIL %s_bits: got %b (unsteady=%0d) expected %b", name, obs, glitch, exp_bits);
    end
    total++;
    if (fd_at != nbits * CPB || fd_cnt != 1) begin
      bad++;
      $display("FAIL %s_done: pulse at %0d count %0d, expected at %0d count 1",
               name, fd_at, fd_cnt, nbits * CPB);
    end
    total++;
    if (busy_cnt != nbits * CPB) begin
      bad++;
      $display("FAIL %s_busy: high %0d cycles, expected %0d", name, busy_cnt, nbits * CPB);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx_w !== 4'hF) begin bad++; $display("FAIL reset_tx: got %b expected 1111", tx_w); end
    total++;
    if (busy_w !== 4'h0) begin bad++; $display("FAIL reset_busy: got %b expected 0000", busy_w); end
    total++;
    if (fd_w !== 4'h0) begin bad++; $display("FAIL reset_done: got %b expected 0000", fd_w); end
    total++;
    if (shift_w !== 4'h0) begin bad++; $display("FAIL reset_pop: got %b expected 0000", shift_w); end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int p;
    push(0, 8'hA5);
    en[0] = 1'b1;
    run_frame(0, "single_a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 0, p);
    @(negedge clk);
    total++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: tx=%b busy=%b expected tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    total++;
    if (pops[0] != 1) begin bad++; $display("FAIL single_pops: got %0d expected 1", pops[0]); end
  endtask

  task automatic test_back_to_back();
    int p1, p2, p3;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    run_frame(0, "b2b_00", {2'b00, 1'b1, 8'h00, 1'b0}, 10, 0, p1);
    run_frame(0, "b2b_ff", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 0, p2);
    run_frame(0, "b2b_3c", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 0, p3);
    total++;
    if (p2 - p1 != 40 || p3 - p2 != 40) begin
      bad++;
      $display("FAIL b2b_spacing: gaps %0d,%0d expected 40,40", p2 - p1, p3 - p2);
    end
    total++;
    if (wr[0] !== rd[0]) begin bad++; $display("FAIL b2b_empty: wr=%0d rd=%0d expected equal", wr[0], rd[0]); end
    repeat (2) @(negedge clk);
    total++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: tx=%b busy=%b expected tx=1 busy=0", tx_w[0], busy_w[0]);
    end
  endtask

  task automatic test_empty_idle();
    int n_pop = 0;
    int n_low = 0;
    int n_busy = 0;
    en[0] = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (shift_w[0] !== 1'b0) n_pop++;
      if (tx_w[0] !== 1'b1) n_low++;
      if (busy_w[0] !== 1'b0) n_busy++;
    end
    total++;
    if (n_pop != 0) begin bad++; $display("FAIL empty_pop: strobes %0d expected 0", n_pop); end
    total++;
    if (n_low != 0) begin bad++; $display("FAIL empty_tx: cycles not idle %0d expected 0", n_low); end
    total++;
    if (n_busy != 0) begin bad++; $display("FAIL empty_busy: busy cycles %0d expected 0", n_busy); end
  endtask

  task automatic test_enable_drop();
    int p;
    int n_pop = 0;
    push(0, 8'h11);
    push(0, 8'h22);
    en[0] = 1'b1;
    run_frame(0, "endrop_11", {2'b00, 1'b1, 8'h11, 1'b0}, 10, 10, p);
    repeat (20) begin
      @(negedge clk);
      if (shift_w[0] !== 1'b0) n_pop++;
    end
    total++;
    if (n_pop != 0 || wr[0] - rd[0] != 4'd1) begin
      bad++;
      $display("FAIL endrop_hold: strobes %0d queued %0d expected 0 and 1", n_pop, wr[0] - rd[0]);
    end
    total++;
    if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL endrop_busy: got %b expected 0", busy_w[0]); end
    en[0] = 1'b1;
    run_frame(0, "endrop_22", {2'b00, 1'b1, 8'h22, 1'b0}, 10, 0, p);
  endtask

  task automatic test_reset_mid();
    int p;
    int pops_start;
    int waited = 0;
    push(0, 8'h5A);
    push(0, 8'hC3);
    #1;
    while (shift_w[0] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    pops_start = pops[0];
    repeat (12) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    total++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || fd_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_out: tx=%b busy=%b done=%b expected 1,0,0", tx_w[0], busy_w[0], fd_w[0]);
    end
    total++;
    if (shift_w[0] !== 1'b0) begin bad++; $display("FAIL rstmid_pop_in_reset: got %b expected 0", shift_w[0]); end
    res = 1'b0;
    total++;
    if (pops[0] != pops_start + 1) begin
      bad++;
      $display("FAIL rstmid_pops: got %0d expected %0d", pops[0], pops_start + 1);
    end
    run_frame(0, "rstmid_c3", {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 0, p);
  endtask

  task automatic test_parity();
    int p;
    push(1, 8'hA5);
    push(1, 8'h01);
    push(2, 8'hA5);
    push(2, 8'h01);
    en[1] = 1'b1;
    run_frame(1, "even_a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, p);
    run_frame(1, "even_01", {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, p);
    en[1] = 1'b0;
    en[2] = 1'b1;
    run_frame(2, "odd_a5", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 0, p);
    run_frame(2, "odd_01", {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 0, p);
    en[2] = 1'b0;
  endtask

  task automatic test_stop2();
    int p;
    push(3, 8'hA5);
    en[3] = 1'b1;
    run_frame(3, "stop2_a5", {1'b0, 2'b11, 8'hA5, 1'b0}, 11, 0, p);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_idle();
    test_enable_drop();
    test_reset_mid();
    test_parity();
    test_stop2();
    repeat (4) @(negedge clk);
    total++;
    if (viol != 0) begin bad++; $display("FAIL pop_while_empty: strobes %0d expected 0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
